pwm_sync_loader: RTL and testbench

PWM_SYNC_LOADER -- requirements
Module: pwm_sync_loader

---
 rtl/pwm_sync_loader_pkg.sv | 17 +
 rtl/pwm_req_fifo.sv | 60 ++++++
 rtl/pwm_sync_loader.sv | 152 +++++++++++++++
 tb/tb_pwm_sync_loader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_sync_loader_pkg.sv
// Shared types and default constants for the PWM synchronous loader.
// Imported by the loader top and its request FIFO.
package pwm_sync_loader_pkg;

   localparam int unsigned NCH_DEF        = 8;
   localparam int unsigned W_DEF          = 28;
   localparam int unsigned DEPTH_DEF      = 4;
   localparam int unsigned PERIOD_RST_DEF = 1000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_STAGE,
      ST_HOLD
   } ld_state_e;

endpackage

// File: rtl/pwm_req_fifo.sv
// Synchronous request FIFO for the PWM loader: DEPTH entries of DW bits,
// show-ahead read port, push ignored when full, pop ignored when empty.
module pwm_req_fifo
   import pwm_sync_loader_pkg::*;
#(
   parameter int unsigned DW    = 59,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pwm_sync_loader.sv
// Queues period/duty update requests and loads them into per-channel shadow
// registers, committing shadow to active only on that channel's counter wrap.
module pwm_sync_loader
   import pwm_sync_loader_pkg::*;
#(
   parameter int unsigned NCH        = NCH_DEF,
   parameter int unsigned W          = W_DEF,
   parameter int unsigned DEPTH      = DEPTH_DEF,
   parameter int unsigned PERIOD_RST = PERIOD_RST_DEF
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [$clog2(NCH)-1:0]  wr_chan,
   input  logic [W-1:0]            wr_period,
   input  logic [W-1:0]            wr_decode,
   input  logic [NCH-1:0]          wrap,
   output logic [NCH*W-1:0]        period_out,
   output logic [NCH*W-1:0]        decode_out,
   output logic [NCH-1:0]          pending,
   output logic                    err,
   input  logic                    err_clr
);

   localparam int unsigned CW = $clog2(NCH);
   localparam int unsigned DW = CW + 2 * W;

   ld_state_e       state;
   logic [CW-1:0]   st_chan;
   logic [W-1:0]    st_period;
   logic [W-1:0]    st_decode;

   logic [DW-1:0]   fifo_din;
   logic [DW-1:0]   fifo_dout;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic [CW-1:0]   head_chan;
   logic [W-1:0]    head_period;
   logic [W-1:0]    head_decode;

   logic            chan_free;
   logic            load_go;

   logic [W-1:0]    shadow_period [NCH];
   logic [W-1:0]    shadow_decode [NCH];
   logic [W-1:0]    act_period    [NCH];
   logic [W-1:0]    act_decode    [NCH];

   assign wr_ready = ~fifo_full;
   assign push     = wr_valid & wr_ready;
   assign pop      = (state == ST_CHECK);
   assign fifo_din = {wr_chan, wr_period, wr_decode};
   assign {head_chan, head_period, head_decode} = fifo_dout;

   pwm_req_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RST_N),
      .push  (push),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A wrap on this edge frees the channel, so the new shadow can land while
   // the old one commits (the old value goes active, the new one stays pending).
   assign chan_free = ~pending[st_chan] | wrap[st_chan];
   assign load_go   = ((state == ST_STAGE) || (state == ST_HOLD)) && chan_free;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         st_chan   <= '0;
         st_period <= '0;
         st_decode <= '0;
         err       <= 1'b0;
      end else begin
         if (err_clr) begin
            err <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (head_period == '0) begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end else begin
                  st_chan   <= head_chan;
                  st_period <= head_period;
                  st_decode <= (head_decode > head_period) ? head_period : head_decode;
                  state     <= ST_STAGE;
               end
            end
            ST_STAGE: begin
               state <= load_go ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
               if (load_go) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            pending[i]       <= 1'b0;
            shadow_period[i] <= '0;
            shadow_decode[i] <= '0;
            act_period[i]    <= W'(PERIOD_RST);
            act_decode[i]    <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (wrap[i] && pending[i]) begin
               act_period[i] <= shadow_period[i];
               act_decode[i] <= shadow_decode[i];
               pending[i]    <= 1'b0;
            end
            if (load_go && (st_chan == CW'(i))) begin
               shadow_period[i] <= st_period;
               shadow_decode[i] <= st_decode;
               pending[i]       <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      period_out = '0;
      decode_out = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         period_out[i*W +: W] = act_period[i];
         decode_out[i*W +: W] = act_decode[i];
      end
   end

endmodule

// File: tb/tb_pwm_sync_loader.sv
// Directed bench for pwm_sync_loader: a request-timeline model predicts
// every output each cycle; literal checks pin key scenarios.
module tb_pwm_sync_loader;

   localparam int NCH   = 8;
   localparam int W     = 28;
   localparam int DEPTH = 4;
   localparam int PRST  = 1000;

   logic               CLK = 1'b0;
   logic               RST_N = 1'b0;
   logic               wr_valid = 1'b0;
   logic               wr_ready;
   logic [2:0]         wr_chan = '0;
   logic [W-1:0]       wr_period = '0;
   logic [W-1:0]       wr_decode = '0;
   logic [NCH-1:0]     wrap = '0;
   logic [NCH*W-1:0]   period_out;
   logic [NCH*W-1:0]   decode_out;
   logic [NCH-1:0]     pending;
   logic               err;
   logic               err_clr = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   pwm_sync_loader #(
      .NCH        (NCH),
      .W          (W),
      .DEPTH      (DEPTH),
      .PERIOD_RST (PRST)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_chan    (wr_chan),
      .wr_period  (wr_period),
      .wr_decode  (wr_decode),
      .wrap       (wrap),
      .period_out (period_out),
      .decode_out (decode_out),
      .pending    (pending),
      .err        (err),
      .err_clr    (err_clr)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] pout(input int ch);
      return period_out[ch*W +: W];
   endfunction

   function automatic logic [W-1:0] dout(input int ch);
      return decode_out[ch*W +: W];
   endfunction

   // Model: requests carry their acceptance edge; the loader pops the head
   // two edges after acceptance or after it last went idle, and writes the
   // shadow from the next edge on, as soon as the channel is not pending
   // (a wrap on the same edge counts as not pending).
   typedef struct {
      int          ch;
      int unsigned p;
      int unsigned d;
      longint      acc;
   } req_t;

   req_t        q[$];
   req_t        cur;
   bit          busy;
   longint      wr_edge;
   longint      idle_since;
   longint      cyc;
   int unsigned m_shp[NCH];
   int unsigned m_shd[NCH];
   int unsigned m_acp[NCH];
   int unsigned m_acd[NCH];
   bit          m_pend[NCH];
   bit          m_err;

   task automatic model_reset();
      q.delete();
      busy       = 1'b0;
      wr_edge    = 0;
      idle_since = -100;
      cyc        = 0;
      m_err      = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         m_shp[i]  = 0;
         m_shd[i]  = 0;
         m_acp[i]  = PRST;
         m_acd[i]  = 0;
         m_pend[i] = 1'b0;
      end
   endtask

   initial begin : model
      bit     old_pend[NCH];
      bit     acc_now;
      longint start;
      req_t   nr;
      model_reset();
      forever begin
         @(posedge CLK or negedge RST_N);
         if (!RST_N) begin
            model_reset();
         end else begin
            cyc++;
            old_pend = m_pend;
            acc_now  = wr_valid && (q.size() < DEPTH);
            for (int i = 0; i < NCH; i++) begin
               if (wrap[i] && old_pend[i]) begin
                  m_acp[i]  = m_shp[i];
                  m_acd[i]  = m_shd[i];
                  m_pend[i] = 1'b0;
               end
            end
            if (err_clr) m_err = 1'b0;
            if (busy) begin
               if (cyc >= wr_edge && !(old_pend[cur.ch] && !wrap[cur.ch])) begin
                  m_shp[cur.ch]  = cur.p;
                  m_shd[cur.ch]  = cur.d;
                  m_pend[cur.ch] = 1'b1;
                  busy           = 1'b0;
                  idle_since     = cyc;
               end
            end else if (q.size() > 0) begin
               start = (q[0].acc > idle_since) ? q[0].acc : idle_since;
               if (cyc >= start + 2) begin
                  cur = q.pop_front();
                  if (cur.p == 0) begin
                     m_err      = 1'b1;
                     idle_since = cyc;
                  end else begin
                     if (cur.d > cur.p) cur.d = cur.p;
                     busy    = 1'b1;
                     wr_edge = cyc + 1;
                  end
               end
            end
            if (acc_now) begin
               nr.ch  = int'(wr_chan);
               nr.p   = int'(wr_period);
               nr.d   = int'(wr_decode);
               nr.acc = cyc;
               q.push_back(nr);
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge CLK);
         if (RST_N) begin
            chk("wr_ready", 64'(wr_ready), 64'(q.size() < DEPTH));
            chk("err", 64'(err), 64'(m_err));
            for (int i = 0; i < NCH; i++) begin
               chk($sformatf("pending[%0d]", i), 64'(pending[i]), 64'(m_pend[i]));
               chk($sformatf("period[%0d]", i), 64'(pout(i)), 64'(m_acp[i]));
               chk($sformatf("decode[%0d]", i), 64'(dout(i)), 64'(m_acd[i]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic send(input int ch, input int unsigned p, input int unsigned d);
      int n;
      wr_chan   = 3'(ch);
      wr_period = W'(p);
      wr_decode = W'(d);
      wr_valid  = 1'b1;
      n = 0;
      while (!wr_ready && n < 200) begin
         tick();
         n++;
      end
      if (!wr_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: wr_ready got 0 expected 1 for ch %0d", ch);
      end
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic pulse_wrap(input int ch);
      wrap     = '0;
      wrap[ch] = 1'b1;
      tick();
      wrap     = '0;
   endtask

   initial begin : stim
      ticks(2);
      RST_N = 1'b1;
      tick();
      for (int i = 0; i < NCH; i++) begin
         chk($sformatf("rst_period[%0d]", i), 64'(pout(i)), 64'd1000);
         chk($sformatf("rst_decode[%0d]", i), 64'(dout(i)), 64'd0);
      end
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_ready", 64'(wr_ready), 64'd1);

      // ch2 update: pending exactly three edges after acceptance
      send(2, 500, 250);
      tick();
      chk("lat_p2_e1", 64'(pending[2]), 64'd0);
      tick();
      chk("lat_p2_e2", 64'(pending[2]), 64'd0);
      tick();
      chk("lat_p2_e3", 64'(pending[2]), 64'd1);
      ticks(3);
      chk("p2_before_wrap", 64'(pout(2)), 64'd1000);
      pulse_wrap(2);
      chk("p2_after_wrap", 64'(pout(2)), 64'd500);
      chk("d2_after_wrap", 64'(dout(2)), 64'd250);
      chk("pend2_after_wrap", 64'(pending[2]), 64'd0);
      chk("model_p2", 64'(m_acp[2]), 64'd500);

      // zero period rejected, err sticky until cleared
      send(1, 0, 5);
      ticks(4);
      chk("err_set", 64'(err), 64'd1);
      chk("err_no_pend", 64'(pending), 64'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_cleared", 64'(err), 64'd0);
      // clear coincident with a rejection: set wins
      send(1, 0, 9);
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_set_wins", 64'(err), 64'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      // decode clamp
      send(0, 100, 300);
      ticks(4);
      pulse_wrap(0);
      chk("clamp_d0", 64'(dout(0)), 64'd100);
      chk("clamp_p0", 64'(pout(0)), 64'd100);

      // HOLD stalls the queue until the FIFO fills
      send(3, 10, 1);
      send(3, 20, 2);
      send(4, 40, 4);
      send(6, 60, 30);
      send(7, 70, 80);
      send(1, 11, 0);
      chk("fifo_full_ready", 64'(wr_ready), 64'd0);
      chk("model_full", 64'(q.size()), 64'd4);
      pulse_wrap(3);
      chk("p3_first", 64'(pout(3)), 64'd10);
      chk("pend3_second", 64'(pending[3]), 64'd1);
      ticks(20);
      chk("p7_shadow_pending", 64'(pending[7]), 64'd1);
      pulse_wrap(3);
      chk("p3_second", 64'(pout(3)), 64'd20);
      pulse_wrap(7);
      chk("d7_clamped", 64'(dout(7)), 64'd70);
      chk("model_d7", 64'(m_acd[7]), 64'd70);

      // wrap coincident with the STAGE write to a pending channel
      send(5, 50, 5);
      ticks(4);
      send(5, 60, 6);
      ticks(2);
      pulse_wrap(5);
      chk("p5_old_commit", 64'(pout(5)), 64'd50);
      chk("pend5_new", 64'(pending[5]), 64'd1);
      ticks(2);
      pulse_wrap(5);
      chk("p5_new_commit", 64'(pout(5)), 64'd60);

      // reset while a request sits in HOLD and another is queued
      send(5, 70, 7);
      ticks(4);
      send(5, 80, 8);
      send(6, 9, 1);
      ticks(3);
      RST_N = 1'b0;
      #3;
      chk("rst_mid_p5", 64'(pout(5)), 64'd1000);
      chk("rst_mid_pending", 64'(pending), 64'd0);
      chk("rst_mid_ready", 64'(wr_ready), 64'd1);
      tick();
      RST_N = 1'b1;
      ticks(8);
      chk("post_rst_pending", 64'(pending), 64'd0);
      chk("post_rst_p6", 64'(pout(6)), 64'd1000);
      chk("post_rst_err", 64'(err), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
